// File: rtl/crc_tx_sequencer.sv
// Transmit frame sequencer: forwards MAC bytes to the PHY side, pads short frames
// to MIN_LEN, waits for the external CRC engine and appends the FCS LSB-first.
module crc_tx_sequencer #(
    parameter int unsigned MIN_LEN     = 60,
    parameter int unsigned CRC_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] crc_data,
    output logic        crc_data_valid,
    output logic        crc_en,
    output logic        crc_clear,
    input  logic [31:0] crc_result,
    input  logic        crc_done,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned CNT_W    = 11;
    localparam int unsigned CNT_P1_W = CNT_W + 1;
    localparam int unsigned WAIT_W   = (CRC_TIMEOUT < 1) ? 1 : $clog2(CRC_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
    localparam logic [CNT_P1_W-1:0] MIN_LEN_W  = CNT_P1_W'(MIN_LEN);
    localparam logic [WAIT_W-1:0]   TIMEOUT_W  = WAIT_W'(CRC_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        WAIT_CRC,
        FCS
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [31:0]         r_fcs;
    logic [1:0]          r_fcs_idx;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_byte_cnt_nxt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic [31:0]         w_fcs_nxt;
    logic [1:0]          w_fcs_idx_nxt;

    logic [CNT_P1_W-1:0] w_cnt_plus1;
    logic [CNT_W-1:0]    w_cnt_sat;
    logic [7:0]          w_fcs_byte;

    // Byte count after the current transfer: unsaturated for the length compare,
    // saturated for the stored value.
    assign w_cnt_plus1 = {1'b0, r_byte_cnt} + CNT_P1_W'(1);
    assign w_cnt_sat   = (r_byte_cnt == CNT_MAX) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);

    always_comb begin
        case (r_fcs_idx)
            2'd0:    w_fcs_byte = r_fcs[7:0];
            2'd1:    w_fcs_byte = r_fcs[15:8];
            2'd2:    w_fcs_byte = r_fcs[23:16];
            default: w_fcs_byte = r_fcs[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_fcs      <= '0;
            r_fcs_idx  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_fcs      <= w_fcs_nxt;
            r_fcs_idx  <= w_fcs_idx_nxt;
        end
    end

    // Next state and handshake outputs; reset holds every output low except crc_clear.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_wait_cnt_nxt = '0;
        w_fcs_nxt      = r_fcs;
        w_fcs_idx_nxt  = r_fcs_idx;

        tx_ready       = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_last       = 1'b0;
        crc_data       = '0;
        crc_data_valid = 1'b0;
        crc_en         = 1'b0;
        crc_clear      = 1'b0;
        busy           = 1'b0;
        frame_err      = 1'b0;

        if (rst) begin
            crc_clear = 1'b1;
        end else begin
            busy = (r_state != IDLE);
            case (r_state)
                IDLE, DATA: begin
                    tx_ready  = out_ready;
                    out_valid = tx_valid;
                    out_data  = tx_data;
                    if (tx_valid && out_ready) begin
                        crc_data       = {24'h0, tx_data};
                        crc_data_valid = 1'b1;
                        crc_en         = 1'b1;
                        w_byte_cnt_nxt = w_cnt_sat;
                        if (!tx_last) begin
                            w_state_nxt = DATA;
                        end else if (w_cnt_plus1 < MIN_LEN_W) begin
                            w_state_nxt = PAD;
                        end else begin
                            w_state_nxt = WAIT_CRC;
                        end
                    end
                end

                PAD: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        crc_data_valid = 1'b1;
                        crc_en         = 1'b1;
                        w_byte_cnt_nxt = w_cnt_sat;
                        if (w_cnt_plus1 >= MIN_LEN_W) begin
                            w_state_nxt = WAIT_CRC;
                        end
                    end
                end

                WAIT_CRC: begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                    // A result arriving on the timeout cycle still wins.
                    if (crc_done) begin
                        w_fcs_nxt     = crc_result;
                        w_fcs_idx_nxt = '0;
                        w_state_nxt   = FCS;
                    end else if (r_wait_cnt >= TIMEOUT_W) begin
                        frame_err   = 1'b1;
                        crc_clear   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end

                FCS: begin
                    out_valid = 1'b1;
                    out_data  = w_fcs_byte;
                    out_last  = (r_fcs_idx == 2'd3);
                    if (out_ready) begin
                        w_fcs_idx_nxt = r_fcs_idx + 2'd1;
                        if (r_fcs_idx == 2'd3) begin
                            crc_clear   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (w_state_nxt == IDLE) begin
                w_byte_cnt_nxt = '0;
            end
        end
    end

endmodule
